keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 matrix keypad and turns physical presses into one-cycle key events for the sequence-loading logic inside `Top`. It drives `col` one-hot and reads `fila`. Each key is debounced on press and on release. It emits one `tecla_valida` pulse with a 4-bit code per press. It sits directly upstream of the character buffer / 7-segment / motor stages.

## Interface
Parameters:
- `SCAN_DIV`, 50_000: clock cycles each column stays driven while scanning (1 ms at 50 MHz); legal values ≥ 2.
- `DEB_CYCLES`, 500_000: consecutive stable cycles required to accept a press or a release (10 ms); legal values ≥ 1.

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `reset`, input, 1: asynchronous, active-high reset. This is the only clock and the only reset.
- `fila`, input, 4: keypad rows, active-high, asynchronous to `clk`.
- `col`, output, 4: column drive, one-hot, active-high.
- `tecla`, output, 4: code of the last accepted key; holds its value until the next accepted key.
- `tecla_valida`, output, 1: one-cycle pulse when a new `tecla` is registered.

## Operation
- Input synchronisation:
  - `fila` passes through a 2-flop synchroniser; the result is `fila_s`.
  - All decisions use `fila_s` only.
- Key map, using row index r (the `fila` bit) and column index c (the `col` bit):
  - r0: c0 = 1, c1 = 2, c2 = 3, c3 = A.
  - r1: c0 = 4, c1 = 5, c2 = 6, c3 = B.
  - r2: c0 = 7, c1 = 8, c2 = 9, c3 = C.
  - r3: c0 = *, c1 = 0, c2 = #, c3 = D.
- Codes: digits map to 0x0–0x9. A = 0xA, B = 0xB, C = 0xC, D = 0xD, * = 0xE, # = 0xF.
- State machine, states SCAN, DEB_PRESS, HOLD, DEB_REL:
  - SCAN:
    - The scan counter runs 0..SCAN_DIV-1.
    - At count SCAN_DIV-1, `fila_s` is evaluated.
    - If `fila_s` is exactly one-hot: capture the row and the current `col`, clear the debounce counter, go to DEB_PRESS. `col` is frozen.
    - Otherwise (zero rows, or multiple rows): rotate `col` left (0001→0010→0100→1000→0001), clear the scan counter, stay in SCAN.
  - DEB_PRESS:
    - Each cycle `fila_s` equals the captured row, the debounce counter increments.
    - Any mismatch: go to SCAN, clear the scan counter, rotate `col` to the next column. No event is emitted.
    - On the DEB_CYCLES-th consecutive match: register `tecla`, pulse `tecla_valida` on the next cycle, go to HOLD.
  - HOLD:
    - `col` stays frozen.
    - When `fila_s` == 0: clear the debounce counter and go to DEB_REL.
  - DEB_REL:
    - Count consecutive cycles with `fila_s` == 0.
    - Any nonzero `fila_s`: return to HOLD.
    - After DEB_CYCLES zero cycles: go to SCAN with `col` = 0001 and the scan counter cleared.
- A second key pressed while one is held is ignored; at most one event is emitted per press.
- Counter widths are derived with `$clog2` from the parameters. No wrap-around occurs inside a state.

## Timing
- Reset values (asynchronous):
  - `col` = 4'b0001, `tecla` = 4'h0, `tecla_valida` = 0.
  - State = SCAN, all counters = 0, synchroniser = 0.
- Reset asserted mid-operation (any state) returns immediately to the reset values. No `tecla_valida` is emitted for an interrupted press.
- Press latency:
  - The row must be stable in `fila_s` at the column-slot end sample, plus for DEB_CYCLES cycles.
  - `tecla_valida` rises 1 cycle after the last matching cycle.
  - `fila_s` trails `fila` by 2 cycles.
- `tecla` changes in the same cycle `tecla_valida` is high, and is stable afterwards.
- `tecla_valida` is never high on two consecutive cycles.
- Release latency: DEB_CYCLES + 2 cycles after `fila` goes to 0, scanning resumes at column 0.
- Simultaneous events:
  - Multi-row reading at a slot end is treated as no key.
  - A mismatch on the same cycle the count completes counts as a mismatch (no event).

## Test plan
All scenarios use SCAN_DIV=4 and DEB_CYCLES=3.

1. Reset, `fila`=0 for 40 cycles: `col` cycles 0001→0010→0100→1000→0001 every 4 cycles. `tecla_valida` never asserts. `tecla`=0.
2. Hold `fila`=0001 while `col`=1000 (key A): exactly one pulse with `tecla`=0xA. Release; after 5 cycles `col` returns to 0001 and rotation resumes. Repeat with rows 0010 and 0100: codes 0xB, then 0xC.
3. Bounce: `fila` high for 2 cycles then low during DEB_PRESS → no pulse, `col` advances to the next column. A stable press afterwards → one pulse.
4. Press `fila`=1000 on column 0100, then add `fila`=1001 during HOLD, then release all → a single pulse with code 0xF (#). Release bounce (0 for 2 cycles, 1 for 1 cycle, then 0) → still no second pulse.
5. `fila`=0011 held across all columns → never accepted, rotation continues.
6. Assert `reset` during DEB_PRESS and during HOLD → outputs return to reset values immediately. No pulse is emitted. Scanning restarts at 0001 after `reset` deasserts.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time. Each press
// and each release is debounced. Every accepted press produces one
// single-cycle tecla_valida pulse, and tecla carries the key code.
module keypad_scanner #(
  parameter int SCAN_DIV   = 50_000,  // cycles per column slot, >= 2
  parameter int DEB_CYCLES = 500_000  // stable cycles to accept press/release, >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [3:0] tecla,
  output logic       tecla_valida
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HOLD, DEB_REL} state_t;

  state_t        state, next_state;
  logic [3:0]    fila_m, fila_s;
  logic [3:0]    row_q;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;

  // Datapath strobes decoded from the current state and inputs
  logic scan_clr, scan_inc, deb_clr, deb_inc;
  logic capture, rotate, col_home, accept;

  logic       one_hot, scan_end, deb_end, row_match, rows_idle;
  logic [1:0] row_idx, col_idx;
  logic [3:0] key_code;

  assign one_hot   = (fila_s != 4'h0) && ((fila_s & (fila_s - 4'd1)) == 4'h0);
  assign scan_end  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign deb_end   = (deb_cnt == DW'(DEB_CYCLES - 1));
  assign row_match = (fila_s == row_q);
  assign rows_idle = (fila_s == 4'h0);

  // Two-flop synchroniser bringing the asynchronous rows into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // update from the pre-edge values regardless of statement order.
    if (reset) begin
      fila_m <= 4'h0;
      fila_s <= 4'h0;
    end else begin
      fila_m <= fila;
      fila_s <= fila_m;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would otherwise infer a latch.
    next_state = state;
    case (state)
      SCAN:      if (scan_end && one_hot) next_state = DEB_PRESS;
      DEB_PRESS: if (!row_match)          next_state = SCAN;
                 else if (deb_end)        next_state = HOLD;
      HOLD:      if (rows_idle)           next_state = DEB_REL;
      DEB_REL:   if (!rows_idle)          next_state = HOLD;
                 else if (deb_end)        next_state = SCAN;
      default:                            next_state = SCAN;
    endcase
  end

  // Output/control decode: tells the datapath what to do this cycle
  always_comb begin
    scan_clr = 1'b0;
    scan_inc = 1'b0;
    deb_clr  = 1'b0;
    deb_inc  = 1'b0;
    capture  = 1'b0;
    rotate   = 1'b0;
    col_home = 1'b0;
    accept   = 1'b0;
    case (state)
      SCAN: begin
        if (!scan_end) begin
          scan_inc = 1'b1;
        end else if (one_hot) begin
          capture = 1'b1;
          deb_clr = 1'b1;
        end else begin
          rotate   = 1'b1;
          scan_clr = 1'b1;
        end
      end
      DEB_PRESS: begin
        if (!row_match) begin
          rotate   = 1'b1;
          scan_clr = 1'b1;
        end else if (deb_end) begin
          accept = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end
      HOLD: begin
        if (rows_idle) deb_clr = 1'b1;
      end
      DEB_REL: begin
        if (rows_idle) begin
          if (deb_end) begin
            col_home = 1'b1;
            scan_clr = 1'b1;
          end else begin
            deb_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Key code lookup from the captured row and the frozen column
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_q[i]) row_idx = 2'(i);
      if (col[i])   col_idx = 2'(i);
    end
    case ({row_idx, col_idx})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;  // *
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;  // #
      default: key_code = 4'hD;
    endcase
  end

  // Datapath: counters, column drive, captured row and the key event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt     <= '0;
      deb_cnt      <= '0;
      row_q        <= 4'h0;
      col          <= 4'b0001;
      tecla        <= 4'h0;
      tecla_valida <= 1'b0;
    end else begin
      if (scan_clr)      scan_cnt <= '0;
      else if (scan_inc) scan_cnt <= scan_cnt + SW'(1);

      if (deb_clr)      deb_cnt <= '0;
      else if (deb_inc) deb_cnt <= deb_cnt + DW'(1);

      if (capture) row_q <= fila_s;

      if (col_home)    col <= 4'b0001;
      else if (rotate) col <= {col[2:0], col[3]};

      tecla_valida <= accept;
      if (accept) tecla <= key_code;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives keypad_scanner with directed and random row
// patterns and compares col/tecla/tecla_valida every cycle against a
// deadline-based behavioural model of the scanner.
module tb_keypad_scanner;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 3;

  localparam int PH_SCAN  = 0;  // looking for a key at the end of each slot
  localparam int PH_PRESS = 1;  // waiting for the press to prove stable
  localparam int PH_HOLD  = 2;  // key accepted, waiting for all rows idle
  localparam int PH_REL   = 3;  // waiting for the release to prove stable

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fila;
  logic [3:0] col;
  logic [3:0] tecla;
  logic       tecla_valida;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Reference model state
  string      keys = "123A456B789C*0#D";
  int         m_cyc;
  int         m_phase;
  int         m_col;
  int         m_deadline;
  logic [3:0] m_row;
  logic [3:0] m_tecla;
  logic       m_valid;
  logic [3:0] pipe[$];

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .fila         (fila),
    .col          (col),
    .tecla        (tecla),
    .tecla_valida (tecla_valida)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(input byte ch);
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
    if (ch == "*") return 4'hE;
    return 4'hF;
  endfunction

  function automatic int index_of(input logic [3:0] onehot_row);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (onehot_row[i]) idx = i;
    return idx;
  endfunction

  task automatic model_reset();
    m_cyc      = 0;
    m_phase    = PH_SCAN;
    m_col      = 0;
    m_deadline = SCAN_DIV - 1;
    m_row      = 4'h0;
    m_tecla    = 4'h0;
    m_valid    = 1'b0;
    pipe       = {4'h0, 4'h0};
  endtask

  // One clock edge of the model; fs is what the scanner sees this edge
  task automatic model_step(input logic [3:0] f);
    logic [3:0] fs;
    fs = pipe.pop_front();
    pipe.push_back(f);
    m_valid = 1'b0;
    case (m_phase)
      PH_SCAN: if (m_cyc == m_deadline) begin
        if ($countones(fs) == 1) begin
          m_phase    = PH_PRESS;
          m_row      = fs;
          m_deadline = m_cyc + DEB_CYCLES;
        end else begin
          m_col      = (m_col + 1) % 4;
          m_deadline = m_cyc + SCAN_DIV;
        end
      end
      PH_PRESS: if (fs != m_row) begin
        m_phase    = PH_SCAN;
        m_col      = (m_col + 1) % 4;
        m_deadline = m_cyc + SCAN_DIV;
      end else if (m_cyc == m_deadline) begin
        m_tecla = code_of(keys[index_of(m_row) * 4 + m_col]);
        m_valid = 1'b1;
        m_phase = PH_HOLD;
      end
      PH_HOLD: if (fs == 4'h0) begin
        m_phase    = PH_REL;
        m_deadline = m_cyc + DEB_CYCLES;
      end
      default: if (fs != 4'h0) begin
        m_phase = PH_HOLD;
      end else if (m_cyc == m_deadline) begin
        m_phase    = PH_SCAN;
        m_col      = 0;
        m_deadline = m_cyc + SCAN_DIV;
      end
    endcase
    m_cyc++;
  endtask

  // Drive one cycle of rows, advance model and DUT, then compare
  task automatic tick(input logic [3:0] f);
    fila = f;
    model_step(f);
    @(posedge clk);
    #1;
    check("col", col, 4'b0001 << m_col);
    check("tecla", tecla, m_tecla);
    check("tecla_valida", tecla_valida, m_valid);
    if (tecla_valida) pulses++;
  endtask

  // Idle until the model has just started a fresh slot on column c
  task automatic wait_slot(input int c);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_phase == PH_SCAN && m_col == c && m_deadline - m_cyc == SCAN_DIV - 1) found = 1;
      else tick(4'h0);
    end
    check("wait_slot", found, 1);
  endtask

  task automatic press_key(input int c, input logic [3:0] rows, input int hold, input int rel);
    wait_slot(c);
    for (int i = 0; i < hold; i++) tick(rows);
    for (int i = 0; i < rel; i++) tick(4'h0);
  endtask

  // Assert reset mid-cycle and check the outputs clear without a clock
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    fila  = 4'h0;
    #1;
    check("rst_col", col, 4'b0001);
    check("rst_tecla", tecla, 4'h0);
    check("rst_valid", tecla_valida, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_col", col, 4'b0001);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int kind, len, c, r, p0;
    logic [3:0] v;
    bit reached;

    reset = 1'b1;
    fila  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("init_col", col, 4'b0001);
    check("init_tecla", tecla, 4'h0);
    check("init_valid", tecla_valida, 1'b0);
    reset = 1'b0;
    model_reset();

    // Idle rotation
    pulses = 0;
    repeat (40) tick(4'h0);
    check("idle_pulses", pulses, 0);

    // Keys A, B, C on column 3
    pulses = 0;
    press_key(3, 4'b0001, 12, 10);
    check("key_A_pulses", pulses, 1);
    check("key_A_code", tecla, 4'hA);
    pulses = 0;
    press_key(3, 4'b0010, 12, 10);
    check("key_B_pulses", pulses, 1);
    check("key_B_code", tecla, 4'hB);
    pulses = 0;
    press_key(3, 4'b0100, 12, 10);
    check("key_C_pulses", pulses, 1);
    check("key_C_code", tecla, 4'hC);

    // Press bounce: row visible at the slot end, then drops while debouncing
    pulses = 0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (m_phase == PH_SCAN && m_deadline == m_cyc + 2) reached = 1;
      else tick(4'h0);
    end
    check("bounce_slot", reached, 1);
    c = m_col;
    tick(4'b0010);
    tick(4'b0010);
    repeat (6) tick(4'h0);
    check("bounce_pulses", pulses, 0);
    check("bounce_col_moved", col, 4'b0001 << ((c + 1) % 4));
    press_key(1, 4'b0100, 12, 10);
    check("after_bounce_pulses", pulses, 1);
    check("after_bounce_code", tecla, 4'h8);

    // '#' with a second key added during hold and a bouncy release
    pulses = 0;
    wait_slot(2);
    repeat (8) tick(4'b1000);
    repeat (4) tick(4'b1001);
    repeat (2) tick(4'h0);
    tick(4'b0001);
    repeat (12) tick(4'h0);
    check("hash_pulses", pulses, 1);
    check("hash_code", tecla, 4'hF);

    // Two rows at once is never a key
    pulses = 0;
    repeat (40) tick(4'b0011);
    check("multi_pulses", pulses, 0);
    repeat (10) tick(4'h0);

    // Reset during press debounce
    pulses = 0;
    wait_slot(1);
    reached = 0;
    for (int i = 0; i < 12 && !reached; i++) begin
      tick(4'b0010);
      if (m_phase == PH_PRESS) reached = 1;
    end
    check("reach_press", reached, 1);
    pulse_reset();
    repeat (12) tick(4'h0);
    check("rst_press_pulses", pulses, 0);

    // Reset while a key is held
    wait_slot(0);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      tick(4'b0001);
      if (m_phase == PH_HOLD) reached = 1;
    end
    check("reach_hold", reached, 1);
    pulse_reset();
    pulses = 0;
    repeat (12) tick(4'h0);
    check("rst_hold_pulses", pulses, 0);

    // Random traffic: idle gaps, physical key presses, raw row noise
    for (int seg = 0; seg < 160; seg++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          len = $urandom_range(1, 14);
          repeat (len) tick(4'h0);
        end
        1: begin
          c   = $urandom_range(0, 3);
          r   = $urandom_range(0, 3);
          len = $urandom_range(3, 30);
          p0  = pulses;
          for (int i = 0; i < len; i++) tick((m_col == c) ? 4'(1 << r) : 4'h0);
          repeat (DEB_CYCLES + 4) tick(4'h0);
          check("rand_press_at_most_one", (pulses - p0) <= 1, 1);
        end
        default: begin
          len = $urandom_range(1, 10);
          for (int i = 0; i < len; i++) begin
            v = 4'($urandom_range(0, 15));
            tick(v);
          end
        end
      endcase
    end
    repeat (20) tick(4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
